// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse element sender.
// The inter-letter gap (LGAP) is only entered when MORSE_LETTER_GAP_EN is defined.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        GAP,
        LGAP,
        DONE
    } state_t;

    localparam int MAX_ELEMS        = 4;
    localparam int DOT_UNITS        = 1;
    localparam int DASH_UNITS       = 3;
    localparam int GAP_UNITS        = 1;
    localparam int LETTER_GAP_UNITS = 3;

    localparam int CODE_W = 4;
    localparam int SIZE_W = 3;

    // Oversized counts play the full four-element pattern.
    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] size);
        return (size > SIZE_W'(MAX_ELEMS)) ? SIZE_W'(MAX_ELEMS) : size;
    endfunction

endpackage

// File: rtl/morse_sender.sv
// Keys an LED with one Morse letter (dots, dashes, gaps) per start pulse.
// Define MORSE_LETTER_GAP_EN to append a 3-unit inter-letter gap before DONE.
module morse_sender
    import morse_pkg::*;
#(
    parameter int UNIT_TICKS = 25_000_000,
    parameter int CNT_W      = $clog2(3*UNIT_TICKS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic [SIZE_W-1:0] size_i,
    output logic              led_o,
    output logic              busy_o,
    output logic              done_o
);

`ifdef MORSE_LETTER_GAP_EN
    localparam bit LETTER_GAP = 1'b1;
`else
    localparam bit LETTER_GAP = 1'b0;
`endif

    localparam logic [CNT_W-1:0] DOT_CNT  = CNT_W'(DOT_UNITS * UNIT_TICKS);
    localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_UNITS * UNIT_TICKS);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_UNITS * UNIT_TICKS);
    localparam logic [CNT_W-1:0] LGAP_CNT = CNT_W'(LETTER_GAP_UNITS * UNIT_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic [CODE_W-1:0] sh_reg,    sh_next;
    logic [SIZE_W-1:0] rem_reg,   rem_next;

    function automatic logic [CNT_W-1:0] elem_cnt(input logic is_dash);
        return is_dash ? DASH_CNT : DOT_CNT;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sh_reg    <= '0;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sh_reg    <= sh_next;
            rem_reg   <= rem_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sh_next    = sh_reg;
        rem_next   = rem_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    sh_next  = code_i;
                    rem_next = clamp_size(size_i);
                    if (size_i == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = MARK;
                        cnt_next   = elem_cnt(code_i[0]);
                    end
                end
            end
            MARK: begin
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) begin
                    rem_next = rem_reg - SIZE_W'(1);
                    sh_next  = sh_reg >> 1;
                    if (rem_reg == SIZE_W'(1)) begin
                        if (LETTER_GAP) begin
                            state_next = LGAP;
                            cnt_next   = LGAP_CNT;
                        end else begin
                            state_next = DONE;
                        end
                    end else begin
                        state_next = GAP;
                        cnt_next   = GAP_CNT;
                    end
                end
            end
            GAP: begin
                cnt_next = cnt_reg - CNT_ONE;
                // sh was already shifted at the end of the previous mark.
                if (cnt_reg == CNT_ONE) begin
                    state_next = MARK;
                    cnt_next   = elem_cnt(sh_reg[0]);
                end
            end
            LGAP: begin
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign led_o  = (state_reg == MARK);
    assign busy_o = (state_reg != IDLE);
    assign done_o = (state_reg == DONE);

endmodule
